// File: rtl/tiger_dm_pkg.sv
// Shared types and constants for the tiger_tiger data-master Avalon bridge.
// Imported by the lane aligner and the bridge FSM.
package tiger_dm_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_REQ,
        ST_WAIT_DATA,
        ST_DONE
    } dm_state_e;

    typedef enum logic [1:0] {
        SZ_BYTE,
        SZ_HALF,
        SZ_WORD
    } dm_size_e;

    localparam logic [3:0] BE_WORD    = 4'hF;
    localparam logic [3:0] BE_HALF_LO = 4'h3;
    localparam logic [3:0] BE_HALF_HI = 4'hC;
    localparam logic [3:0] BE_BYTE0   = 4'h1;
    localparam logic [3:0] BE_BYTE1   = 4'h2;
    localparam logic [3:0] BE_BYTE2   = 4'h4;
    localparam logic [3:0] BE_BYTE3   = 4'h8;

    localparam logic [31:0] DEF_ERROR_READDATA = 32'hDEADBEEF;

    // mem8 takes priority over mem16; neither means a full word.
    function automatic dm_size_e size_of(input logic mem8, input logic mem16);
        dm_size_e s;
        s = SZ_WORD;
        if (mem8) begin
            s = SZ_BYTE;
        end else if (mem16) begin
            s = SZ_HALF;
        end
        return s;
    endfunction

endpackage

// File: rtl/tiger_dm_lane_align.sv
// Lane steering for the data master: byteenables, store replication
// and right-aligned, zero-extended load extraction.
module tiger_dm_lane_align
    import tiger_dm_pkg::*;
(
    input  logic [1:0]  addr_lo,
    input  dm_size_e    size,
    input  logic [31:0] wdata_in,
    input  logic [31:0] rdata_in,
    output logic [3:0]  byteenable,
    output logic [31:0] wdata_out,
    output logic [31:0] rdata_out
);

    logic [1:0]  lane;
    logic [31:0] shifted;

    always_comb begin
        lane       = 2'd0;
        byteenable = BE_WORD;
        wdata_out  = wdata_in;
        unique case (size)
            SZ_BYTE: begin
                lane      = addr_lo;
                wdata_out = {4{wdata_in[7:0]}};
                unique case (addr_lo)
                    2'd0:    byteenable = BE_BYTE0;
                    2'd1:    byteenable = BE_BYTE1;
                    2'd2:    byteenable = BE_BYTE2;
                    default: byteenable = BE_BYTE3;
                endcase
            end
            SZ_HALF: begin
                // Halfwords ignore addr[0] and sit on lane 0 or lane 2.
                lane       = {addr_lo[1], 1'b0};
                wdata_out  = {2{wdata_in[15:0]}};
                byteenable = addr_lo[1] ? BE_HALF_HI : BE_HALF_LO;
            end
            default: begin
                lane = 2'd0;
            end
        endcase
    end

    always_comb begin
        shifted   = rdata_in >> {lane, 3'b000};
        rdata_out = shifted;
        unique case (size)
            SZ_BYTE: rdata_out = {24'd0, shifted[7:0]};
            SZ_HALF: rdata_out = {16'd0, shifted[15:0]};
            default: rdata_out = shifted;
        endcase
    end

endmodule

// File: rtl/tiger_dm_avalon_bridge.sv
// Single-outstanding bridge from the tiger_tiger load/store port to an
// Avalon data master, with a per-transaction watchdog.
module tiger_dm_avalon_bridge
    import tiger_dm_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 1024,
    parameter logic [31:0] ERROR_READDATA = DEF_ERROR_READDATA
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] memaddress,
    input  logic        memread,
    input  logic        memwrite,
    input  logic        mem8,
    input  logic        mem16,
    input  logic [31:0] memwritedata,
    output logic [31:0] memreaddata,
    output logic        avalon_stall,
    output logic        bus_error,
    output logic [31:0] avm_dataMaster_address,
    output logic        avm_dataMaster_read,
    output logic        avm_dataMaster_write,
    output logic [31:0] avm_dataMaster_writedata,
    output logic [3:0]  avm_dataMaster_byteenable,
    input  logic [31:0] avm_dataMaster_readdata,
    input  logic        avm_dataMaster_waitrequest,
    input  logic        avm_dataMaster_readdatavalid
);

    localparam logic [31:0] TMO_LAST = 32'(TIMEOUT_CYCLES - 1);

    dm_state_e   state_q, state_d;
    dm_size_e    size_q, size_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic        write_q, write_d;
    logic [31:0] cnt_q, cnt_d;
    logic [31:0] rdata_q, rdata_d;
    logic        bus_error_q, bus_error_d;

    logic [31:0] rdata_aligned;
    logic        timeout;
    logic        accepted;

    tiger_dm_lane_align u_align (
        .addr_lo    (addr_q[1:0]),
        .size       (size_q),
        .wdata_in   (wdata_q),
        .rdata_in   (avm_dataMaster_readdata),
        .byteenable (avm_dataMaster_byteenable),
        .wdata_out  (avm_dataMaster_writedata),
        .rdata_out  (rdata_aligned)
    );

    assign avm_dataMaster_address = {addr_q[31:2], 2'b00};
    assign avm_dataMaster_read    = (state_q == ST_REQ) && !write_q;
    assign avm_dataMaster_write   = (state_q == ST_REQ) && write_q;
    assign memreaddata            = rdata_q;
    assign bus_error              = bus_error_q;

    assign timeout  = (cnt_q >= TMO_LAST);
    assign accepted = !avm_dataMaster_waitrequest;

    always_comb begin
        state_d      = state_q;
        size_d       = size_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        write_d      = write_q;
        cnt_d        = cnt_q;
        rdata_d      = rdata_q;
        bus_error_d  = bus_error_q;
        avalon_stall = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                if (memread || memwrite) begin
                    avalon_stall = 1'b1;
                    state_d      = ST_REQ;
                    addr_d       = memaddress;
                    size_d       = size_of(mem8, mem16);
                    wdata_d      = memwritedata;
                    write_d      = memwrite;
                end
            end
            ST_REQ: begin
                avalon_stall = 1'b1;
                cnt_d        = cnt_q + 32'd1;
                if (accepted && write_q) begin
                    state_d = ST_DONE;
                end else if (accepted && avm_dataMaster_readdatavalid) begin
                    state_d = ST_DONE;
                    rdata_d = rdata_aligned;
                end else if (timeout) begin
                    state_d     = ST_DONE;
                    bus_error_d = 1'b1;
                    if (!write_q) begin
                        rdata_d = ERROR_READDATA;
                    end
                end else if (accepted) begin
                    state_d = ST_WAIT_DATA;
                end
            end
            ST_WAIT_DATA: begin
                avalon_stall = 1'b1;
                cnt_d        = cnt_q + 32'd1;
                if (avm_dataMaster_readdatavalid) begin
                    state_d = ST_DONE;
                    rdata_d = rdata_aligned;
                end else if (timeout) begin
                    state_d     = ST_DONE;
                    bus_error_d = 1'b1;
                    rdata_d     = ERROR_READDATA;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            size_q      <= SZ_WORD;
            addr_q      <= '0;
            wdata_q     <= '0;
            write_q     <= 1'b0;
            cnt_q       <= '0;
            rdata_q     <= '0;
            bus_error_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            size_q      <= size_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            write_q     <= write_d;
            cnt_q       <= cnt_d;
            rdata_q     <= rdata_d;
            bus_error_q <= bus_error_d;
        end
    end

endmodule

// File: doc/tiger_dm_avalon_bridge.md
Name: tiger_dm_avalon_bridge

Overview:
Data-master bridge between the tiger_tiger core's load/store port and the Avalon data master. It captures one core memory request, drives a single word-aligned Avalon read or write with lane byteenables, and stalls the core until completion. Load data is returned lane-aligned and zero-extended, so the top level needs no readdata muxing. A watchdog bounds each transaction.

Parameters:
TIMEOUT_CYCLES, 1024, maximum cycles in REQ+WAIT_DATA before forced completion (>=2)
ERROR_READDATA, 32'hDEADBEEF, load data returned on timeout

Ports:
clk  in  1  clock
reset  in  1  asynchronous active-high reset
memaddress  in  32  core byte address
memread  in  1  core load request
memwrite  in  1  core store request
mem8  in  1  byte access
mem16  in  1  halfword access (mem8 has priority)
memwritedata  in  32  store data, value in low lanes
memreaddata  out  32  aligned, zero-extended load data
avalon_stall  out  1  stall to core (dStall)
bus_error  out  1  sticky timeout flag
avm_dataMaster_address  out  32  word-aligned address
avm_dataMaster_read  out  1  Avalon read
avm_dataMaster_write  out  1  Avalon write
avm_dataMaster_writedata  out  32  lane-replicated store data
avm_dataMaster_byteenable  out  4  lane enables
avm_dataMaster_readdata  in  32  Avalon read data
avm_dataMaster_waitrequest  in  1  slave busy
avm_dataMaster_readdatavalid  in  1  read data valid

Behaviour:
- Reset (async): state IDLE; read=write=0; address=0; byteenable=4'hF; writedata=0; memreaddata=0; bus_error=0; timeout counter=0.
- States: IDLE, REQ, WAIT_DATA, DONE.
- IDLE: if memread|memwrite, capture address/size/data/direction, go to REQ. avalon_stall=1 combinationally in that same cycle. memwrite wins if both are set.
- Byteenable (little-endian):
  - word: F
  - half: addr[1]=0 -> 3, addr[1]=1 -> C
  - byte: addr[1:0] 0/1/2/3 -> 1/2/4/8
  - addr[0] is ignored for halfwords.
- Address output = {addr[31:2],2'b00}.
- Writedata: byte replicated x4, halfword replicated x2, word as-is.
- REQ: read or write held asserted with stable address/data/byteenable while waitrequest=1.
  - Write, waitrequest=0 -> DONE.
  - Read, waitrequest=0 -> WAIT_DATA. If readdatavalid is also high that cycle -> DONE directly.
- WAIT_DATA: read/write deasserted. On readdatavalid, latch readdata into the hold register -> DONE.
- Alignment: shift the latched word right by the lane offset, then mask to 8/16/32 bits with zero-fill. memreaddata comes from the hold register and is stable from DONE until the next load completes.
- DONE: avalon_stall=0 for exactly one cycle, then IDLE. A new request is only sampled in IDLE.
  - Minimum latency, write with zero wait: 3 cycles with stall high for 2.
  - Minimum latency, read: 3 cycles.
- avalon_stall=1 in REQ and WAIT_DATA.
- Watchdog:
  - Counter clears in IDLE and increments in REQ and WAIT_DATA.
  - At TIMEOUT_CYCLES-1: force DONE, deassert read/write, set bus_error (sticky until reset), and load memreaddata=ERROR_READDATA on reads.
  - A readdatavalid arriving after a timeout is ignored.
- readdatavalid outside WAIT_DATA/REQ is ignored.
- Reset mid-transaction aborts immediately; outputs return to reset values.

Decomposition:
- Shared package tiger_dm_pkg: state enum, byteenable constants (BE_WORD, BE_HALF_LO/HI, BE_BYTE0..3), default ERROR_READDATA.
- One sub-module, tiger_dm_lane_align: combinational size/offset -> byteenable, writedata replication, and readdata extraction. Reused by the FSM top.

Test Plan:
1. Word store: addr 0x100, data 0xA5A5_1234, waitrequest=0 -> write=1, address 0x100, byteenable F, writedata 0xA5A51234; stall high 2 cycles, low in DONE.
2. Byte load: addr 0x203, slave returns 0x11223344 after 2 wait cycles + 1 latency -> address 0x200, byteenable 8, memreaddata 0x00000011, stall released the cycle after readdatavalid.
3. Halfword store: addr 0x302, data 0x0000BEEF, waitrequest high 3 cycles -> write and signals stable 4 cycles, byteenable C, writedata 0xBEEFBEEF.
4. Timeout: TIMEOUT_CYCLES=8, read, readdatavalid never asserted -> stall drops after 8 cycles, memreaddata 0xDEADBEEF, bus_error=1 and stays set; a late readdatavalid has no effect.
5. Reset asserted in WAIT_DATA -> read=0, stall=0, bus_error=0 immediately; next load after reset completes normally.
6. memread and memwrite both high -> write transaction only; back-to-back loads each incur the DONE→IDLE gap.
